// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, shift-add MULT, optional restoring DIV.
// Define MULTICYCLE_ALU_DIV_EN to build the DIV state and the 011010 DIV function.
module multicycle_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       alu_funct,
  input  logic [1:0]       alu_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             ZERO
);

  localparam int unsigned CntW = $clog2(WIDTH);

`ifdef MULTICYCLE_ALU_DIV_EN
  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;
`endif

  state_e              state_q;
  logic                busy_q, done_q, zero_q;
  logic [WIDTH-1:0]    result_q, hi_q, opnd_q;
  logic [2*WIDTH-1:0]  acc_q;
  logic [CntW-1:0]     cnt_q;

  logic [WIDTH-1:0]    single_res;
  logic                is_mul;
  logic                last_iter;
  logic [WIDTH:0]      mul_sum;
  logic [2*WIDTH-1:0]  mul_next;
`ifdef MULTICYCLE_ALU_DIV_EN
  logic                is_div;
  logic [WIDTH:0]      div_shift;
  logic [WIDTH-1:0]    div_sub;
  logic                div_ge;
  logic [2*WIDTH-1:0]  div_next;
`endif

  // Operation decode; unrecognised codes fall through to a zero result.
  always_comb begin
    single_res = '0;
    is_mul     = 1'b0;
`ifdef MULTICYCLE_ALU_DIV_EN
    is_div     = 1'b0;
`endif
    case (alu_op)
      2'b00:   single_res = A + B;
      2'b01:   single_res = A - B;
      default: begin
        case (alu_funct)
          6'b100100: single_res = A & B;
          6'b100101: single_res = A | B;
          6'b100000: single_res = A + B;
          6'b100010: single_res = A - B;
          6'b101010: single_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
          6'b011000: is_mul = 1'b1;
`ifdef MULTICYCLE_ALU_DIV_EN
          6'b011010: is_div = 1'b1;
`endif
          default:   single_res = '0;
        endcase
      end
    endcase
  end

  // acc_q holds {partial product, remaining multiplier} for MULT.
  always_comb begin
    last_iter = (cnt_q == CntW'(WIDTH - 1));
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
  end

`ifdef MULTICYCLE_ALU_DIV_EN
  // acc_q holds {remainder, dividend/quotient} for DIV; B=0 yields all-ones and rem=A.
  always_comb begin
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_sub   = div_shift[WIDTH-1:0] - opnd_q;
    div_next  = {(div_ge ? div_sub : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          if (start) begin
            if (is_mul) begin
              acc_q   <= {{WIDTH{1'b0}}, B};
              opnd_q  <= A;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= StMul;
            end
`ifdef MULTICYCLE_ALU_DIV_EN
            else if (is_div) begin
              acc_q   <= {{WIDTH{1'b0}}, A};
              opnd_q  <= B;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= StDiv;
            end
`endif
            else begin
              result_q <= single_res;
              hi_q     <= '0;
              zero_q   <= (single_res == '0);
              done_q   <= 1'b1;
              state_q  <= StDone;
            end
          end
        end
        StMul: begin
          acc_q <= mul_next;
          cnt_q <= cnt_q + CntW'(1);
          if (last_iter) begin
            result_q <= mul_next[WIDTH-1:0];
            hi_q     <= mul_next[2*WIDTH-1:WIDTH];
            zero_q   <= (mul_next[WIDTH-1:0] == '0);
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            cnt_q    <= '0;
            state_q  <= StDone;
          end
        end
`ifdef MULTICYCLE_ALU_DIV_EN
        StDiv: begin
          acc_q <= div_next;
          cnt_q <= cnt_q + CntW'(1);
          if (last_iter) begin
            result_q <= div_next[WIDTH-1:0];
            hi_q     <= div_next[2*WIDTH-1:WIDTH];
            zero_q   <= (div_next[WIDTH-1:0] == '0);
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            cnt_q    <= '0;
            state_q  <= StDone;
          end
        end
`endif
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign hi     = hi_q;
  assign ZERO   = zero_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu at WIDTH=32.
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] A, B;
  logic [5:0]  alu_funct;
  logic [1:0]  alu_op;
  logic        busy, done, ZERO;
  logic [31:0] result, hi;

  int tests_run = 0;
  int tests_failed = 0;

  multicycle_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
    .alu_funct(alu_funct), .alu_op(alu_op), .busy(busy), .done(done),
    .result(result), .hi(hi), .ZERO(ZERO)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input logic [5:0] f);
    A = a; B = b; alu_op = op; alu_funct = f; start = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; A = '0; B = '0; alu_op = '0; alu_funct = '0;
    cyc(); cyc();
    tests_run++;
    if ({busy, done, result, hi, ZERO} !== {1'b0, 1'b0, 32'd0, 32'd0, 1'b1}) begin
      $display("FAIL reset_state: got busy=%b done=%b result=%h hi=%h ZERO=%b want 0 0 0 0 1",
               busy, done, result, hi, ZERO);
      tests_failed++;
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_add();
    issue(32'd30, 32'd25, 2'b10, 6'b100000);
    cyc(); start = 1'b0;
    tests_run++;
    if ({done, result, hi, ZERO} !== {1'b1, 32'd55, 32'd0, 1'b0}) begin
      $display("FAIL add_30_25: got done=%b result=%0d hi=%0d ZERO=%b want 1 55 0 0",
               done, result, hi, ZERO);
      tests_failed++;
    end
    cyc();
    tests_run++;
    if ({done, result} !== {1'b0, 32'd55}) begin
      $display("FAIL add_hold: got done=%b result=%0d want 0 55", done, result);
      tests_failed++;
    end
  endtask

  task automatic test_single_ops();
    issue(32'd5, 32'd5, 2'b01, 6'b000000);
    cyc(); start = 1'b0;
    tests_run++;
    if ({done, result, ZERO} !== {1'b1, 32'd0, 1'b1}) begin
      $display("FAIL sub_5_5: got done=%b result=%h ZERO=%b want 1 0 1", done, result, ZERO);
      tests_failed++;
    end
    cyc();
    issue(32'hFFFF_FFFD, 32'd2, 2'b10, 6'b101010);
    cyc(); start = 1'b0;
    tests_run++;
    if ({done, result, ZERO} !== {1'b1, 32'd1, 1'b0}) begin
      $display("FAIL slt_m3_2: got done=%b result=%h ZERO=%b want 1 1 0", done, result, ZERO);
      tests_failed++;
    end
    cyc();
    issue(32'd2, 32'hFFFF_FFFD, 2'b11, 6'b101010);
    cyc(); start = 1'b0;
    tests_run++;
    if ({result, ZERO} !== {32'd0, 1'b1}) begin
      $display("FAIL slt_2_m3: got result=%h ZERO=%b want 0 1", result, ZERO);
      tests_failed++;
    end
    cyc();
    issue(32'h0000_F0F0, 32'h0000_FF00, 2'b10, 6'b100100);
    cyc(); start = 1'b0;
    tests_run++;
    if (result !== 32'h0000_F000) begin
      $display("FAIL and: got result=%h want 0000f000", result);
      tests_failed++;
    end
    cyc();
    issue(32'h0000_F0F0, 32'h0000_FF00, 2'b10, 6'b100101);
    cyc(); start = 1'b0;
    tests_run++;
    if (result !== 32'h0000_FFF0) begin
      $display("FAIL or: got result=%h want 0000fff0", result);
      tests_failed++;
    end
    cyc();
    issue(32'hFFFF_FFFF, 32'd1, 2'b00, 6'b000000);
    cyc(); start = 1'b0;
    tests_run++;
    if ({result, ZERO} !== {32'd0, 1'b1}) begin
      $display("FAIL add_wrap: got result=%h ZERO=%b want 0 1", result, ZERO);
      tests_failed++;
    end
    cyc();
    issue(32'd3, 32'd10, 2'b10, 6'b100010);
    cyc(); start = 1'b0;
    tests_run++;
    if (result !== 32'hFFFF_FFF9) begin
      $display("FAIL sub_funct_wrap: got result=%h want fffffff9", result);
      tests_failed++;
    end
    cyc();
  endtask

  // Run one long operation; counts sampled cycles from acceptance until done.
  task automatic run_long(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f,
                          output int cycles, output int busy_cnt, output logic held);
    logic [31:0] prev_res, prev_hi;
    prev_res = result; prev_hi = hi;
    held = 1'b1; busy_cnt = 0;
    issue(a, b, 2'b10, f);
    cyc();
    cycles = 1;
    while (!done && cycles < 40) begin
      if (busy) busy_cnt++;
      if (result !== prev_res || hi !== prev_hi) held = 1'b0;
      // Stray start pulses while iterating must be ignored.
      if (cycles == 5 || cycles == 20) issue(32'd7, 32'd7, 2'b10, 6'b100000);
      else start = 1'b0;
      cyc();
      cycles++;
    end
    start = 1'b0;
  endtask

  task automatic test_mult();
    int cycles, busy_cnt;
    logic held;
    run_long(32'h0001_0000, 32'h0001_0000, 6'b011000, cycles, busy_cnt, held);
    tests_run++;
    if ({done, result, hi, ZERO} !== {1'b1, 32'd0, 32'd1, 1'b1}) begin
      $display("FAIL mult_2p32: got done=%b result=%h hi=%h ZERO=%b want 1 0 1 1",
               done, result, hi, ZERO);
      tests_failed++;
    end
    cyc();
    run_long(32'hFFFF_FFFF, 32'd2, 6'b011000, cycles, busy_cnt, held);
    tests_run++;
    if (cycles != 33) begin
      $display("FAIL mult_latency: got done at cycle %0d want 33", cycles);
      tests_failed++;
    end
    tests_run++;
    if (busy_cnt != 32) begin
      $display("FAIL mult_busy_cycles: got %0d want 32", busy_cnt);
      tests_failed++;
    end
    tests_run++;
    if (held !== 1'b1) begin
      $display("FAIL mult_outputs_held: got held=%b want 1", held);
      tests_failed++;
    end
    tests_run++;
    if ({done, result, hi, ZERO} !== {1'b1, 32'hFFFF_FFFE, 32'd1, 1'b0}) begin
      $display("FAIL mult_ffff_2: got done=%b result=%h hi=%h ZERO=%b want 1 fffffffe 1 0",
               done, result, hi, ZERO);
      tests_failed++;
    end
    cyc();
    tests_run++;
    if ({done, busy} !== 2'b00) begin
      $display("FAIL mult_done_pulse: got done=%b busy=%b want 0 0", done, busy);
      tests_failed++;
    end
  endtask

  task automatic test_unknown();
    issue(32'd9, 32'd9, 2'b10, 6'b111111);
    cyc(); start = 1'b0;
    tests_run++;
    if ({done, result, hi, ZERO} !== {1'b1, 32'd0, 32'd0, 1'b1}) begin
      $display("FAIL unknown_funct: got done=%b result=%h hi=%h ZERO=%b want 1 0 0 1",
               done, result, hi, ZERO);
      tests_failed++;
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    issue(32'd3, 32'd4, 2'b10, 6'b100000);
    cyc();
    issue(32'd1, 32'd1, 2'b10, 6'b100000);
    tests_run++;
    if ({done, result} !== {1'b1, 32'd7}) begin
      $display("FAIL b2b_first: got done=%b result=%0d want 1 7", done, result);
      tests_failed++;
    end
    cyc(); start = 1'b0;
    tests_run++;
    if ({done, result} !== {1'b1, 32'd2}) begin
      $display("FAIL b2b_second: got done=%b result=%0d want 1 2", done, result);
      tests_failed++;
    end
    cyc();
    tests_run++;
    if (done !== 1'b0) begin
      $display("FAIL b2b_idle: got done=%b want 0", done);
      tests_failed++;
    end
  endtask

  task automatic test_div();
`ifdef MULTICYCLE_ALU_DIV_EN
    int cycles, busy_cnt;
    logic held;
    run_long(32'd100, 32'd7, 6'b011010, cycles, busy_cnt, held);
    tests_run++;
    if ({cycles, result, hi} !== {32'd33, 32'd14, 32'd2}) begin
      $display("FAIL div_100_7: got cycle=%0d result=%0d hi=%0d want 33 14 2",
               cycles, result, hi);
      tests_failed++;
    end
    cyc();
    run_long(32'd100, 32'd0, 6'b011010, cycles, busy_cnt, held);
    tests_run++;
    if ({cycles, result, hi} !== {32'd33, 32'hFFFF_FFFF, 32'd100}) begin
      $display("FAIL div_by_zero: got cycle=%0d result=%h hi=%0d want 33 ffffffff 100",
               cycles, result, hi);
      tests_failed++;
    end
    cyc();
`else
    issue(32'd1, 32'd2, 2'b00, 6'b000000);
    cyc(); start = 1'b0;
    cyc();
    issue(32'd100, 32'd7, 2'b10, 6'b011010);
    cyc(); start = 1'b0;
    tests_run++;
    if ({done, busy, result, hi, ZERO} !== {1'b1, 1'b0, 32'd0, 32'd0, 1'b1}) begin
      $display("FAIL div_disabled: got done=%b busy=%b result=%h hi=%h ZERO=%b want 1 0 0 0 1",
               done, busy, result, hi, ZERO);
      tests_failed++;
    end
    cyc();
`endif
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    issue(32'd5, 32'd6, 2'b00, 6'b000000);
    cyc(); start = 1'b0;
    cyc();
    issue(32'hFFFF_FFFF, 32'd3, 2'b10, 6'b011000);
    cyc(); start = 1'b0;
    repeat (8) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    tests_run++;
    if ({busy, done, result, hi, ZERO} !== {1'b0, 1'b0, 32'd0, 32'd0, 1'b1}) begin
      $display("FAIL reset_mid_mult: got busy=%b done=%b result=%h hi=%h ZERO=%b want 0 0 0 0 1",
               busy, done, result, hi, ZERO);
      tests_failed++;
    end
    done_cnt = 0;
    repeat (40) begin
      cyc();
      if (done) done_cnt++;
    end
    tests_run++;
    if (done_cnt != 0) begin
      $display("FAIL reset_no_done: got %0d done pulses want 0", done_cnt);
      tests_failed++;
    end
    // Reset wins over a simultaneous start.
    issue(32'd30, 32'd25, 2'b10, 6'b100000);
    reset = 1'b1;
    cyc();
    reset = 1'b0; start = 1'b0;
    tests_run++;
    if ({done, result, ZERO} !== {1'b0, 32'd0, 1'b1}) begin
      $display("FAIL reset_priority: got done=%b result=%h ZERO=%b want 0 0 1",
               done, result, ZERO);
      tests_failed++;
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_add();
    test_single_ops();
    test_mult();
    test_unknown();
    test_back_to_back();
    test_div();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits (legal 8..64).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; operation accepted when start=1 and state is IDLE or DONE.
REQ-005 A  input  WIDTH  operand A, sampled on acceptance.
REQ-006 B  input  WIDTH  operand B, sampled on acceptance.
REQ-007 alu_funct  input  6  R-type function code, sampled on acceptance.
REQ-008 alu_op  input  2  decode class, sampled on acceptance: 00 add, 01 subtract, 10/11 use alu_funct.
REQ-009 busy  output  1  high while a multi-cycle operation iterates.
REQ-010 done  output  1  one-cycle pulse when result/hi/ZERO are valid.
REQ-011 result  output  WIDTH  registered primary result.
REQ-012 hi  output  WIDTH  registered upper product half, or remainder.
REQ-013 ZERO  output  1  registered, 1 when result == 0.

Function
REQ-014 FSM states IDLE, MUL, DIV, DONE; transitions only on clk rising edge.
REQ-015 Single-cycle ops (alu_op 00/01; funct 100100 AND, 100101 OR, 100000 ADD, 100010 SUB, 101010 SLT signed): on acceptance, result registered, hi cleared to 0, go DONE; done high the next cycle (latency 1).
REQ-016 ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
REQ-017 SLT: result = 1 if signed A < signed B, else 0.
REQ-018 funct 011000 MULT (unsigned): go MUL, busy=1, shift-add one bit per cycle for exactly WIDTH cycles, then DONE; done at acceptance+WIDTH+1; {hi,result} = full 2*WIDTH-bit product.
REQ-019 Unrecognised funct with alu_op 10/11: result=0, hi=0, ZERO=1, latency 1 (no hold of stale value).
REQ-020 DONE lasts exactly one cycle; next state IDLE, or new operation if start=1 in DONE (back-to-back, no bubble).
REQ-021 start while in MUL/DIV is ignored; operands and code are not re-sampled.
REQ-022 result, hi, ZERO hold their values from done until the next accepted operation completes; intermediate iteration values never appear on result/hi.
REQ-023 ZERO evaluated on final result only, valid in the same cycle as done.
REQ-024 busy=0 in IDLE and DONE; done=0 in all states except DONE.

Reset
REQ-025 reset=1 at a clock edge forces state IDLE, busy=0, done=0, result=0, hi=0, ZERO=1, iteration counter=0.
REQ-026 reset mid-MUL/DIV aborts the operation; no done pulse for it follows.
REQ-027 reset has priority over start in the same cycle.

Configuration
REQ-028 Macro MULTICYCLE_ALU_DIV_EN: when defined, funct 011010 DIV (unsigned) enters DIV, restoring division one bit per cycle for WIDTH cycles, done at acceptance+WIDTH+1; result=quotient, hi=remainder.
REQ-029 With MULTICYCLE_ALU_DIV_EN and B=0: result all-ones, hi=A, same latency as normal DIV.
REQ-030 Without MULTICYCLE_ALU_DIV_EN: DIV state absent, funct 011010 handled per REQ-019.

Verification (WIDTH=32)
REQ-031 Reset, then A=30, B=25, alu_op=10, funct=100000, start 1 cycle -> done next cycle, result=55, hi=0, ZERO=0.
REQ-032 A=5, B=5, alu_op=01 -> done after 1 cycle, result=0, ZERO=1; A=-3, B=2, funct=101010 -> result=1.
REQ-033 A=0xFFFFFFFF, B=2, funct=011000 -> busy 32 cycles, done at cycle 33, result=0xFFFFFFFE, hi=1; start pulses during busy ignored.
REQ-034 Back-to-back: start held across DONE with new ADD 1+1 -> second done on the cycle after first, result=2.
REQ-035 reset asserted on cycle 10 of a MULT -> next cycle busy=0, result=0, ZERO=1, no done within 40 cycles.
REQ-036 With MULTICYCLE_ALU_DIV_EN: A=100, B=7, funct=011010 -> done at cycle 33, result=14, hi=2; B=0 -> result=0xFFFFFFFF, hi=100; without macro -> result=0, latency 1.
